// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and CPU/DMA arbiter for the SM83 main bus, OAM RAM and IO/HRAM block.
// Optional feature macro: OAM_DMA_ECHO_REMAP_EN (fold echo-RAM source pages E0-FF onto C0-DF).
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          XFER_LEN     = 160,
    parameter int          START_DELAY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    input  logic [7:0]  oam_rdata,
    output logic        io_we,
    output logic        io_re,
    input  logic [7:0]  io_rdata,
    output logic        dma_active
);
    localparam logic [15:0] START_CNT = 16'(START_DELAY - 1);
    localparam logic [7:0]  LAST_IDX  = 8'(XFER_LEN - 1);
    localparam logic [16:0] OAM_SPAN  = 17'(XFER_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  src_r, src_s, idx_r, idx_s, bus_src_s;
    logic [15:0] cnt_r, cnt_s;
    logic [16:0] oam_off_s;
    logic        dma_active_r;
    logic        is_reg_s, is_iow_s, is_oam_s, is_main_s, reg_we_s, cpu_acc_s;

    assign is_reg_s  = (cpu_addr == DMA_REG_ADDR);
    assign is_iow_s  = (cpu_addr[15:8] == 8'hFF) && !is_reg_s;
    // Addresses below OAM_BASE borrow into bit 16, so one compare bounds both ends.
    assign oam_off_s = {1'b0, cpu_addr} - {1'b0, OAM_BASE};
    assign is_oam_s  = !is_reg_s && !is_iow_s && (oam_off_s < OAM_SPAN);
    assign is_main_s = !is_reg_s && !is_iow_s && !is_oam_s;
    assign reg_we_s  = cpu_we && is_reg_s;
    assign cpu_acc_s = cpu_we || cpu_re;
    assign dma_active = dma_active_r;

`ifdef OAM_DMA_ECHO_REMAP_EN
    assign bus_src_s = (src_r >= 8'hE0) ? (src_r - 8'h20) : src_r;
`else
    assign bus_src_s = src_r;
`endif

    // State, delay counter, byte index and latched source page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            src_r        <= 8'h00;
            idx_r        <= 8'h00;
            cnt_r        <= 16'h0000;
            dma_active_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            src_r        <= src_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            dma_active_r <= (state_s != ST_IDLE);
        end
    end

    // Next-state logic; a register write always (re)starts with a full delay.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        src_s   = src_r;
        if (reg_we_s) begin
            src_s   = cpu_wdata;
            state_s = ST_START;
            cnt_s   = START_CNT;
            idx_s   = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_START: begin
                    if (cnt_r == 16'h0000) begin
                        state_s = ST_XFER;
                        idx_s   = 8'h00;
                    end else begin
                        cnt_s = cnt_r - 16'h0001;
                    end
                end
                ST_XFER: begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_IDLE;
                    end else begin
                        idx_s = idx_r + 8'h01;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Route the CPU port or the DMA engine onto the bus, OAM and IO strobes.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        oam_addr  = oam_off_s[7:0];
        oam_wdata = cpu_wdata;
        oam_we    = 1'b0;
        io_we     = 1'b0;
        io_re     = 1'b0;
        if (!rst_n) begin
            bus_we = 1'b0;
            oam_we = 1'b0;
        end else begin
            io_we = is_iow_s && cpu_we;
            io_re = is_iow_s && cpu_re;
            case (state_r)
                ST_IDLE: begin
                    bus_we = is_main_s && cpu_we;
                    bus_re = is_main_s && cpu_re;
                    oam_we = is_oam_s && cpu_we;
                end
                ST_XFER: begin
                    bus_addr  = {bus_src_s, idx_r};
                    bus_wdata = 8'h00;
                    bus_re    = 1'b1;
                    oam_addr  = idx_r;
                    oam_wdata = bus_rdata;
                    oam_we    = 1'b1;
                end
                default: begin
                    bus_we = 1'b0;
                    bus_re = 1'b0;
                end
            endcase
        end
    end

    // CPU read mux; blocked and unmapped accesses float to FF.
    always_comb begin
        cpu_rdata = 8'hFF;
        if (!cpu_acc_s) begin
            cpu_rdata = 8'hFF;
        end else if (is_reg_s) begin
            cpu_rdata = src_r;
        end else if (is_iow_s) begin
            cpu_rdata = io_rdata;
        end else if (state_r != ST_IDLE) begin
            cpu_rdata = 8'hFF;
        end else if (is_oam_s) begin
            cpu_rdata = oam_rdata;
        end else begin
            cpu_rdata = bus_rdata;
        end
    end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: driver predicts per-cycle responses and OAM writes,
// a negedge monitor pops and compares them against the DUT.
module tb_oam_dma_arbiter;
    localparam int          D     = 1;
    localparam int          LEN   = 160;
    localparam logic [15:0] REG   = 16'hFF46;
    localparam logic [15:0] OBASE = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic [7:0]  cpu_rdata, bus_wdata, bus_rdata, oam_addr, oam_wdata, oam_rdata, io_rdata;
    logic [15:0] bus_addr;
    logic        bus_we, bus_re, oam_we, io_we, io_re, dma_active;

    oam_dma_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_rdata(cpu_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata),
        .io_we(io_we), .io_re(io_re), .io_rdata(io_rdata),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic        chk_rd;
        logic [7:0]  rd;
        logic        io_re;
        logic        io_we;
        logic        bus_re;
        logic        bus_we;
        logic [15:0] baddr;
        logic        act;
    } cyc_rec_t;
    typedef struct {
        int         c;
        logic [7:0] a;
        logic [7:0] d;
    } oam_ent_t;

    cyc_rec_t   cyc_q[$];
    oam_ent_t   oam_q[$];
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] oam     [0:255];
    logic [7:0] ref_oam [0:255];
    logic [7:0] snap    [0:255];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         dma_t = 0;
    logic       dma_on = 1'b0;
    logic [7:0] ref_src = 8'h00;

    function automatic logic [7:0] init_byte(input int a);
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return 8'(a * 37 + (a >> 8) * 11 + 5);
    endfunction

    function automatic logic [7:0] init_oam(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [7:0] eff_src(input logic [7:0] s);
`ifdef OAM_DMA_ECHO_REMAP_EN
        return (s >= 8'hE0) ? (s - 8'h20) : s;
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Devices on the far side of the arbiter.
    assign bus_rdata = mem[bus_addr];
    assign oam_rdata = oam[oam_addr];
    assign io_rdata  = cpu_addr[7:0] ^ 8'hA5;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_byte(i);
            for (int i = 0; i < 256; i++) oam[i] <= init_oam(i);
        end else begin
            if (bus_we) mem[bus_addr] <= bus_wdata;
            if (oam_we) oam[oam_addr] <= oam_wdata;
        end
    end

    // One CPU cycle: apply inputs and predict everything the DUT must show this cycle.
    task automatic drive(input logic [15:0] a, input logic [7:0] wd, input logic we,
                         input logic re, input logic rst);
        cyc_rec_t r;
        oam_ent_t e;
        int       c;
        logic     is_reg, is_io, is_oam, is_main, busy, xf;
        @(posedge clk);
        #1;
        rst_n = ~rst; cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_re = re;
        c = cyc;
        is_reg  = (a == REG);
        is_io   = (a[15:8] == 8'hFF) && !is_reg;
        is_oam  = !is_io && !is_reg && (int'(a) >= int'(OBASE)) && (int'(a) < int'(OBASE) + LEN);
        is_main = !is_reg && !is_io && !is_oam;
        busy    = dma_on && (c > dma_t) && (c <= dma_t + D + LEN);
        xf      = dma_on && (c >= dma_t + 1 + D) && (c <= dma_t + D + LEN);
        r.c = c; r.chk_rd = re || !we; r.rd = 8'hFF; r.io_re = 1'b0; r.io_we = 1'b0;
        r.bus_re = 1'b0; r.bus_we = 1'b0; r.baddr = 16'h0000; r.act = 1'b0;
        if (rst) begin
            while (oam_q.size() > 0 && oam_q[$].c >= c) void'(oam_q.pop_back());
            dma_on = 1'b0;
            ref_src = 8'h00;
        end else begin
            r.act   = busy;
            r.io_re = is_io && re;
            r.io_we = is_io && we;
            if (!re && !we) r.rd = 8'hFF;
            else if (is_reg) r.rd = ref_src;
            else if (is_io) r.rd = a[7:0] ^ 8'hA5;
            else if (busy) r.rd = 8'hFF;
            else if (is_oam) r.rd = ref_oam[8'(a - OBASE)];
            else r.rd = ref_mem[a];
            if (xf) begin
                r.bus_re = 1'b1;
                r.baddr  = {eff_src(ref_src), 8'(c - dma_t - 1 - D)};
            end else if (!busy && is_main) begin
                r.bus_re = re; r.bus_we = we; r.baddr = a;
            end
            if (we && is_reg) begin
                while (oam_q.size() > 0 && oam_q[$].c > c) void'(oam_q.pop_back());
                for (int i = 0; i < LEN; i++) begin
                    e.c = c + 1 + D + i; e.a = 8'(i); e.d = ref_mem[{eff_src(wd), 8'(i)}];
                    oam_q.push_back(e);
                end
                dma_on = 1'b1; dma_t = c; ref_src = wd;
            end else if (we && !busy && is_oam) begin
                e.c = c; e.a = 8'(a - OBASE); e.d = wd;
                oam_q.push_back(e);
            end else if (we && !busy && is_main) begin
                ref_mem[a] = wd;
            end
        end
        cyc_q.push_back(r);
    endtask

    task automatic idle();
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_access();
        int         k;
        logic       w;
        logic [15:0] a;
        k = int'($urandom_range(0, 4));
        w = 1'($urandom_range(0, 1));
        case (k)
            0: begin
                a = {8'hFF, 8'($urandom_range(0, 255))};
                a = (a == REG) ? 16'hFF47 : a;
                drive(a, 8'($urandom), w, !w, 1'b0);
            end
            1: drive(OBASE + 16'($urandom_range(0, 255)), 8'($urandom), w, !w, 1'b0);
            2: drive(16'($urandom_range(0, 32'hFDFF)), 8'($urandom), w, !w, 1'b0);
            3: drive(REG, 8'h00, 1'b0, 1'b1, 1'b0);
            default: idle();
        endcase
    endtask

    task automatic finish_dma();
        while (cyc + 1 <= dma_t + D + LEN) rand_access();
        idle();
    endtask

    // Monitor: compare each predicted cycle and each predicted OAM write.
    always @(negedge clk) begin
        cyc_rec_t r;
        oam_ent_t e;
        if (cyc == 1) for (int i = 0; i < 256; i++) ref_oam[i] = init_oam(i);
        if (cyc_q.size() > 0 && cyc_q[0].c == cyc) begin
            r = cyc_q.pop_front();
            check("dma_active", 32'(dma_active), 32'(r.act));
            if (r.chk_rd) check("cpu_rdata", 32'(cpu_rdata), 32'(r.rd));
            check("io_re", 32'(io_re), 32'(r.io_re));
            check("io_we", 32'(io_we), 32'(r.io_we));
            check("bus_re", 32'(bus_re), 32'(r.bus_re));
            check("bus_we", 32'(bus_we), 32'(r.bus_we));
            if (r.bus_re || r.bus_we) check("bus_addr", 32'(bus_addr), 32'(r.baddr));
        end
        while (oam_q.size() > 0 && oam_q[0].c < cyc) begin
            e = oam_q.pop_front();
            check("oam_write_late", 32'd0, 32'd1);
        end
        if (oam_q.size() > 0 && oam_q[0].c == cyc) begin
            e = oam_q.pop_front();
            check("oam_we", 32'(oam_we), 32'd1);
            if (oam_we) begin
                check("oam_addr", 32'(oam_addr), 32'(e.a));
                check("oam_wdata", 32'(oam_wdata), 32'(e.d));
            end
            ref_oam[e.a] = e.d;
        end else begin
            check("oam_we_quiet", 32'(oam_we), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        int target;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        repeat (3) drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);

        // IDLE routing: OAM write/read, main bus, IO, register.
        drive(16'hFE05, 8'h33, 1'b1, 1'b0, 1'b0);
        drive(16'hFE05, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hC000, 8'h77, 1'b1, 1'b0, 1'b0);
        drive(16'hC000, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hFF85, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hFF85, 8'h12, 1'b1, 1'b0, 1'b0);
        drive(REG, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hFEA4, 8'h00, 1'b0, 1'b1, 1'b0);
        idle();

        // Basic transfer from C100 with blocked CPU traffic in the middle.
        drive(REG, 8'hC1, 1'b1, 1'b0, 1'b0);
        repeat (20) idle();
        drive(16'hC000, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hFE10, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(16'hC000, 8'hEE, 1'b1, 1'b0, 1'b0);
        drive(16'hFE10, 8'hEE, 1'b1, 1'b0, 1'b0);
        drive(16'hFF85, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(REG, 8'h00, 1'b0, 1'b1, 1'b0);
        while (cyc + 1 <= dma_t + D + LEN) idle();
        idle();
        n = 0;
        for (int i = 0; i < LEN; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) n++;
        check("first_copy_bad_bytes", 32'(n), 32'd0);
        check("blocked_write_c000", 32'(mem[16'hC000]), 32'(ref_mem[16'hC000]));

        // Restart at idx 50 with a new source page.
        drive(REG, 8'hC1, 1'b1, 1'b0, 1'b0);
        target = dma_t + 1 + D + 50;
        while (cyc + 1 < target) rand_access();
        drive(REG, 8'hD0, 1'b1, 1'b0, 1'b0);
        finish_dma();
        n = 0;
        for (int i = 0; i < LEN; i++) if (oam[i] !== ref_mem[16'hD000 + i]) n++;
        check("restart_copy_bad_bytes", 32'(n), 32'd0);

        // Reset in the middle of a copy.
        for (int i = 0; i < 256; i++) snap[i] = oam[i];
        drive(REG, 8'hC1, 1'b1, 1'b0, 1'b0);
        target = dma_t + 1 + D + 80;
        while (cyc + 1 < target) idle();
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(REG, 8'h00, 1'b0, 1'b1, 1'b0);
        idle();
        n = 0;
        for (int i = 81; i < LEN; i++) if (oam[i] !== snap[i]) n++;
        check("reset_untouched_tail", 32'(n), 32'd0);

        // Echo-page source, restarted on its final transfer cycle.
        drive(REG, 8'hE2, 1'b1, 1'b0, 1'b0);
        drive(REG, 8'h00, 1'b0, 1'b1, 1'b0);
        target = dma_t + D + LEN;
        while (cyc + 1 < target) rand_access();
        drive(REG, 8'h3C, 1'b1, 1'b0, 1'b0);
        finish_dma();

        // Randomized transfers with optional restarts and random CPU traffic.
        for (int k = 0; k < 4; k++) begin
            repeat (30) rand_access();
            drive(REG, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                target = dma_t + 1 + int'($urandom_range(0, D + LEN - 1));
                while (cyc + 1 < target) rand_access();
                drive(REG, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
            end
            finish_dma();
        end

        repeat (4) idle();
        @(negedge clk);
        #1;
        check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
        check("oam_queue_drained", 32'(oam_q.size()), 32'd0);
        n = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) n++;
        check("main_memory_bad_bytes", 32'(n), 32'd0);
        n = 0;
        for (int i = 0; i < 256; i++) if (oam[i] !== ref_oam[i]) n++;
        check("oam_final_bad_bytes", 32'(n), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
